user_fifo_responder: RTL

USER_FIFO_RESPONDER -- requirements
Module: user_fifo_responder

---
 rtl/user_fifo_responder.sv | 136 +++++++++++++
 1 files changed

// File: rtl/user_fifo_responder.sv
// Show-ahead FIFO behind a four-channel Nios slave register file, with push counter, checksum and sticky flags.
// All user_datain_k registered: state changes at an edge are visible the following cycle.
module user_fifo_responder #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16
) (
    input  logic              clk_clk,
    input  logic              reset_reset_n,
    input  logic [15:0]       user_chipselect,
    input  logic              user_write,
    input  logic              user_read,
    input  logic [DATA_W-1:0] user_dataout_0,
    input  logic [DATA_W-1:0] user_dataout_1,
    input  logic [DATA_W-1:0] user_dataout_2,
    input  logic [DATA_W-1:0] user_dataout_3,
    output logic [DATA_W-1:0] user_datain_0,
    output logic [DATA_W-1:0] user_datain_1,
    output logic [DATA_W-1:0] user_datain_2,
    output logic [DATA_W-1:0] user_datain_3
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [DATA_W-1:0] STAT_RST = DATA_W'(1) << (DATA_W - 4);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr, r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              r_ovf, r_unf;
    logic [DATA_W-1:0] r_push_cnt, r_csum;
    logic              r_wr0_q, r_rd1_q, r_wr3_q;
    logic              r_arm;
    logic [DATA_W-1:0] r_datain_0, r_datain_1, r_datain_2, r_datain_3;

    logic              w_wr0, w_rd1, w_wr3;
    logic              w_push_ev, w_pop_ev, w_ctl_ev;
    logic              w_flush, w_clr_flags, w_clr_stats;
    logic              w_do_push, w_do_pop, w_set_ovf, w_set_unf;
    logic [CNT_W-1:0]  w_cnt_ap, w_count_n;
    logic [PTR_W-1:0]  w_wr_ptr_n, w_rd_ptr_n;
    logic              w_ovf_n, w_unf_n;
    logic [DATA_W-1:0] w_push_cnt_n, w_csum_n, w_head_n, w_status_n;
    logic              w_unused;

    // Only channels 0 (write), 1 (read) and 3 (write, bits 2:0) carry meaning.
    assign w_unused = ^{user_chipselect[15:4], user_dataout_1, user_dataout_2,
                        user_dataout_3[DATA_W-1:3]};

    always_comb begin
        w_wr0       = user_write & user_chipselect[0];
        w_rd1       = user_read  & user_chipselect[1];
        w_wr3       = user_write & user_chipselect[3];
        // r_arm masks the first edge after reset so a strobe held through release never fires.
        w_push_ev   = r_arm & w_wr0 & ~r_wr0_q;
        w_pop_ev    = r_arm & w_rd1 & ~r_rd1_q;
        w_ctl_ev    = r_arm & w_wr3 & ~r_wr3_q;
        w_flush     = w_ctl_ev & user_dataout_3[0];
        w_clr_flags = w_ctl_ev & user_dataout_3[1];
        w_clr_stats = w_ctl_ev & user_dataout_3[2];

        // Pop is evaluated first so a full FIFO can accept a same-edge push.
        w_do_pop  = w_pop_ev & ~w_flush & (r_count != '0);
        w_set_unf = w_pop_ev & ~w_flush & (r_count == '0);
        w_cnt_ap  = r_count - {{(CNT_W-1){1'b0}}, w_do_pop};
        w_do_push = w_push_ev & ~w_flush & (w_cnt_ap != FULL_CNT);
        w_set_ovf = w_push_ev & ~w_flush & (w_cnt_ap == FULL_CNT);

        w_rd_ptr_n = w_flush ? '0 : r_rd_ptr + PTR_W'(w_do_pop);
        w_wr_ptr_n = w_flush ? '0 : r_wr_ptr + PTR_W'(w_do_push);
        w_count_n  = w_flush ? '0 : w_cnt_ap + {{(CNT_W-1){1'b0}}, w_do_push};
        w_ovf_n    = (r_ovf & ~w_clr_flags) | w_set_ovf;
        w_unf_n    = (r_unf & ~w_clr_flags) | w_set_unf;

        w_push_cnt_n = (w_clr_stats ? '0 : r_push_cnt) + DATA_W'(w_do_push);
        w_csum_n     = (w_clr_stats ? '0 : r_csum) + (w_do_push ? user_dataout_0 : '0);

        // A push into an empty FIFO is not in storage yet, so bypass it to the head.
        w_head_n = '0;
        if (w_count_n != '0) begin
            if (w_cnt_ap == '0) w_head_n = user_dataout_0;
            else                w_head_n = r_mem[w_rd_ptr_n];
        end

        w_status_n              = '0;
        w_status_n[DATA_W-1]    = w_ovf_n;
        w_status_n[DATA_W-2]    = w_unf_n;
        w_status_n[DATA_W-3]    = (w_count_n == FULL_CNT);
        w_status_n[DATA_W-4]    = (w_count_n == '0);
        w_status_n[CNT_W-1:0]   = w_count_n;
    end

    always_ff @(posedge clk_clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= user_dataout_0;
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_ovf      <= 1'b0;
            r_unf      <= 1'b0;
            r_push_cnt <= '0;
            r_csum     <= '0;
            r_wr0_q    <= 1'b0;
            r_rd1_q    <= 1'b0;
            r_wr3_q    <= 1'b0;
            r_arm      <= 1'b0;
            r_datain_0 <= '0;
            r_datain_1 <= '0;
            r_datain_2 <= STAT_RST;
            r_datain_3 <= '0;
        end else begin
            r_wr_ptr   <= w_wr_ptr_n;
            r_rd_ptr   <= w_rd_ptr_n;
            r_count    <= w_count_n;
            r_ovf      <= w_ovf_n;
            r_unf      <= w_unf_n;
            r_push_cnt <= w_push_cnt_n;
            r_csum     <= w_csum_n;
            r_wr0_q    <= w_wr0;
            r_rd1_q    <= w_rd1;
            r_wr3_q    <= w_wr3;
            r_arm      <= 1'b1;
            r_datain_0 <= w_push_cnt_n;
            r_datain_1 <= w_head_n;
            r_datain_2 <= w_status_n;
            r_datain_3 <= w_csum_n;
        end
    end

    assign user_datain_0 = r_datain_0;
    assign user_datain_1 = r_datain_1;
    assign user_datain_2 = r_datain_2;
    assign user_datain_3 = r_datain_3;
endmodule
